mul_div_unit: RTL and testbench

Iterative RISC-V M-extension multiply/divide unit for the execute stage, parametrised in operand width. It accepts one operation per start pulse and computes it over DATA_WIDTH cycles, one bit per cycle, using shift-add for multiply and restoring division for divide. While it works it holds a stall request so the pipeline freezes the instruction in execute. Results come back through a one-cycle done pulse and stay on the output until the next start.

---
 rtl/mul_div_unit.sv | 142 ++++++++++++++
 tb/tb_mul_div_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: one result bit per cycle,
// shift-add multiply and restoring divide, with stall/done handshake to execute.
module mul_div_unit #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_start,
  input  logic [2:0]            i_func3,
  input  logic [DATA_WIDTH-1:0] i_src_1,
  input  logic [DATA_WIDTH-1:0] i_src_2,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_n;
  logic [2:0]       func3_q;
  logic             neg_q;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     hold;   // multiplicand for MUL*, divisor for DIV*/REM*
  logic [2*W-1:0]   acc;    // {product hi, multiplier/product lo} or {remainder, quotient}

  // Operand conditioning in IDLE
  logic           is_div_in, signed_a, signed_b, neg_in;
  logic           div_zero, div_ovf, special;
  logic [W-1:0]   abs_a, abs_b, special_res;

  always_comb begin
    is_div_in = i_func3[2];
    signed_a  = (i_func3 == 3'd1) || (i_func3 == 3'd2) || (i_func3 == 3'd4) || (i_func3 == 3'd6);
    signed_b  = (i_func3 == 3'd1) || (i_func3 == 3'd4) || (i_func3 == 3'd6);
    abs_a     = (signed_a && i_src_1[W-1]) ? -i_src_1 : i_src_1;
    abs_b     = (signed_b && i_src_2[W-1]) ? -i_src_2 : i_src_2;
    // REM takes the dividend's sign; everything else the XOR of signed operands
    if (i_func3 == 3'd6)
      neg_in = i_src_1[W-1];
    else
      neg_in = (signed_a & i_src_1[W-1]) ^ (signed_b & i_src_2[W-1]);
    div_zero = is_div_in && (i_src_2 == '0);
    div_ovf  = ((i_func3 == 3'd4) || (i_func3 == 3'd6)) && (i_src_1 == MOST_NEG) && (i_src_2 == '1);
    special  = div_zero || div_ovf;
    if (div_zero)
      special_res = i_func3[1] ? i_src_1 : '1;
    else
      special_res = i_func3[1] ? '0 : i_src_1;
  end

  // One iteration of the datapath
  logic [W:0]     mul_sum, rem_sh;
  logic [W-1:0]   div_diff, quo, rem;
  logic           rem_ge;
  logic [2*W-1:0] acc_mul, acc_div, acc_nx, prod;
  logic [W-1:0]   fin_res;

  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, hold};
    acc_mul  = acc[0] ? {mul_sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
    rem_sh   = acc[2*W-1:W-1];
    rem_ge   = rem_sh >= {1'b0, hold};
    div_diff = rem_sh[W-1:0] - hold;
    acc_div  = rem_ge ? {div_diff, acc[W-2:0], 1'b1} : {rem_sh[W-1:0], acc[W-2:0], 1'b0};
    acc_nx   = func3_q[2] ? acc_div : acc_mul;

    prod = neg_q ? -acc_nx : acc_nx;
    quo  = neg_q ? -acc_nx[W-1:0] : acc_nx[W-1:0];
    rem  = neg_q ? -acc_nx[2*W-1:W] : acc_nx[2*W-1:W];
    case (func3_q)
      3'd0:          fin_res = prod[W-1:0];
      3'd1,
      3'd2,
      3'd3:          fin_res = prod[2*W-1:W];
      3'd4, 3'd5:    fin_res = quo;
      default:       fin_res = rem;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (i_start) state_n = special ? DONE : CALC;
      CALC:    if (cnt == '0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (i_flush) state_n = IDLE;
    o_stall = (i_start && (state == IDLE) && !i_flush) || (state == CALC);
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      func3_q  <= '0;
      neg_q    <= 1'b0;
      cnt      <= '0;
      hold     <= '0;
      acc      <= '0;
      o_result <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_busy <= (state_n == CALC);
      o_done <= (state_n == DONE);
      if (!i_flush) begin
        case (state)
          IDLE: begin
            if (i_start) begin
              func3_q <= i_func3;
              neg_q   <= neg_in;
              if (special) begin
                o_result <= special_res;
              end else begin
                cnt  <= CNT_W'(W - 1);
                hold <= is_div_in ? abs_b : abs_a;
                acc  <= {{W{1'b0}}, (is_div_in ? abs_a : abs_b)};
              end
            end
          end
          CALC: begin
            acc <= acc_nx;
            if (cnt == '0) o_result <= fin_res;
            else           cnt      <= cnt - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus flush, ignored-start and
// mid-operation reset sequences.
module tb_mul_div_unit;

  localparam int W = 64;
  localparam logic [W-1:0] MOST_NEG = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk, arst, start, flush;
  logic [2:0]   func3;
  logic [W-1:0] src_1, src_2;
  logic         stall, busy, done;
  logic [W-1:0] result;

  mul_div_unit #(.DATA_WIDTH(W)) dut (
    .i_clk    (clk),
    .i_arst   (arst),
    .i_start  (start),
    .i_func3  (func3),
    .i_src_1  (src_1),
    .i_src_2  (src_2),
    .i_flush  (flush),
    .o_stall  (stall),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_total = 0;
  always @(negedge clk) if (done === 1'b1) done_total <= done_total + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic to_cycle(input int target);
    while (cyc != target) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [2:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
    string        name;
  } vec_t;

  task automatic run_op(input vec_t v);
    int t_lat;
    int bad;
    t_lat = -1;
    bad   = 0;
    @(posedge clk);
    #1;
    start = 1'b1; flush = 1'b0;
    func3 = v.f; src_1 = v.a; src_2 = v.b;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (stall !== (k < v.lat)) bad++;
      if (busy !== ((k >= 1) && (k < v.lat))) bad++;
      if (done === 1'b1) begin
        t_lat = k;
        break;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    start = 1'b0;
    check({v.name, "_result"}, result, v.exp);
    check({v.name, "_done_cycle"}, W'(t_lat), W'(v.lat));
    check({v.name, "_stall_busy"}, W'(bad), '0);
  endtask

  localparam int NV = 18;
  vec_t vecs[NV];

  initial begin
    int t0, lat, d0, busy_after;

    vecs[0]  = '{3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, "mul_7xm3"};
    vecs[1]  = '{3'd3, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65, "mulhu_max"};
    vecs[2]  = '{3'd1, ONES, ONES, 64'd0, 65, "mulh_m1xm1"};
    vecs[3]  = '{3'd2, ONES, 64'd2, ONES, 65, "mulhsu_m1x2"};
    vecs[4]  = '{3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_m7_2"};
    vecs[5]  = '{3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 65, "rem_m7_2"};
    vecs[6]  = '{3'd5, 64'd100, 64'd7, 64'd14, 65, "divu_100_7"};
    vecs[7]  = '{3'd7, 64'd100, 64'd7, 64'd2, 65, "remu_100_7"};
    vecs[8]  = '{3'd4, 64'd5, 64'd0, ONES, 1, "div_by0"};
    vecs[9]  = '{3'd6, 64'd5, 64'd0, 64'd5, 1, "rem_by0"};
    vecs[10] = '{3'd4, MOST_NEG, ONES, MOST_NEG, 1, "div_ovf"};
    vecs[11] = '{3'd6, MOST_NEG, ONES, 64'd0, 1, "rem_ovf"};
    vecs[12] = '{3'd0, 64'h1234, 64'h10, 64'h12340, 65, "mul_small"};
    vecs[13] = '{3'd1, MOST_NEG, MOST_NEG, 64'h4000_0000_0000_0000, 65, "mulh_minxmin"};
    vecs[14] = '{3'd4, MOST_NEG, 64'd1, MOST_NEG, 65, "div_min_1"};
    vecs[15] = '{3'd5, ONES, 64'd1, ONES, 65, "divu_max_1"};
    vecs[16] = '{3'd5, 64'd9, 64'd0, ONES, 1, "divu_by0"};
    vecs[17] = '{3'd7, 64'd9, 64'd0, 64'd9, 1, "remu_by0"};

    arst = 1'b1; start = 1'b0; flush = 1'b0;
    func3 = '0; src_1 = '0; src_2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_result", result, '0);
    check("rst_done", W'(done), '0);
    check("rst_busy", W'(busy), '0);
    check("rst_stall", W'(stall), '0);
    @(posedge clk);
    #1;
    arst = 1'b0;

    for (int i = 0; i < NV; i++) run_op(vecs[i]);

    // Flush mid-multiply: last result (REMU 9 % 0 = 9) must survive
    @(posedge clk);
    #1;
    d0 = done_total;
    start = 1'b1; func3 = 3'd0; src_1 = 64'd3; src_2 = 64'd5;
    t0 = cyc;
    to_cycle(t0 + 1);
    start = 1'b0;
    to_cycle(t0 + 10);
    flush = 1'b1;
    to_cycle(t0 + 11);
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", W'(busy), '0);
    check("flush_done", W'(done), '0);
    check("flush_stall", W'(stall), '0);
    check("flush_result", result, 64'd9);
    check("flush_no_done_pulse", W'(done_total - d0), '0);
    run_op('{3'd5, 64'd100, 64'd7, 64'd14, 65, "divu_after_flush"});

    // Start pulses in CALC and DONE must be ignored
    @(posedge clk);
    #1;
    start = 1'b1; func3 = 3'd5; src_1 = 64'd200; src_2 = 64'd9;
    t0 = cyc;
    lat = -1;
    busy_after = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done === 1'b1 && lat < 0) lat = k;
      if (k >= 66 && busy !== 1'b0) busy_after++;
      @(posedge clk);
      #1;
      start = ((k + 1) == 5) || ((k + 1) == 65);
      if (start) begin
        func3 = 3'd0; src_1 = 64'd3; src_2 = 64'd5;
      end
    end
    start = 1'b0;
    check("ignore_done_cycle", W'(lat), 64'd65);
    check("ignore_result", result, 64'd22);
    check("ignore_no_restart", W'(busy_after), '0);

    // Reset in cycle 30 of a DIV
    @(posedge clk);
    #1;
    d0 = done_total;
    start = 1'b1; func3 = 3'd4; src_1 = 64'hFFFF_FFFF_FFFF_FFF9; src_2 = 64'd2;
    t0 = cyc;
    to_cycle(t0 + 1);
    start = 1'b0;
    to_cycle(t0 + 30);
    arst = 1'b1;
    to_cycle(t0 + 31);
    arst = 1'b0;
    @(negedge clk);
    check("midrst_result", result, '0);
    check("midrst_busy", W'(busy), '0);
    check("midrst_done", W'(done), '0);
    check("midrst_stall", W'(stall), '0);
    to_cycle(t0 + 80);
    check("midrst_no_done_pulse", W'(done_total - d0), '0);
    run_op('{3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 65, "rem_after_rst"});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
